// File: rtl/sgmii_pkg.sv
// rtl/sgmii_pkg.sv - shared state encoding and bit positions for SGMII auto-negotiation
package sgmii_pkg;

  typedef enum logic [2:0] {
    AN_RESTART,
    ABILITY_DETECT,
    ACK_DETECT,
    COMPLETE_ACK,
    IDLE_DETECT,
    LINK_OK
  } an_state_e;

  localparam int ST_AN_DONE  = 0;
  localparam int ST_LINK_UP  = 1;
  localparam int ST_SPEED_LO = 2;
  localparam int ST_SPEED_HI = 3;
  localparam int ST_DUPLEX   = 4;
  localparam int ST_AN_BUSY  = 5;

  localparam int CW_SPEED_LO = 10;
  localparam int CW_SPEED_HI = 11;
  localparam int CW_DUPLEX   = 12;
  localparam int CW_ACK      = 14;
  localparam int CW_LINK     = 15;

  localparam logic [15:0] CW_ACK_MASK = 16'h4000;

  // Config words are compared with the acknowledge bit masked out.
  function automatic logic cw_match_no_ack(input logic [15:0] a, input logic [15:0] b);
    return ((a ^ b) & ~CW_ACK_MASK) == 16'h0000;
  endfunction

endpackage

// File: rtl/sgmii_an_timer.sv
// rtl/sgmii_an_timer.sv - link_timer: saturating counter cleared on every state entry
module sgmii_an_timer #(
  parameter int LINK_TIMER = 200000
) (
  input  logic clock,
  input  logic reset_n,
  input  logic clear,
  output logic expired
);

  localparam int CNT_W = (LINK_TIMER > 1) ? $clog2(LINK_TIMER) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LINK_TIMER - 1);

  logic [CNT_W-1:0] count;

  // Saturating at the last value keeps expired asserted until the next clear.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (count != CNT_LAST) begin
      count <= count + CNT_W'(1);
    end
  end

  assign expired = (count == CNT_LAST);

endmodule

// File: rtl/sgmii_autoneg.sv
// rtl/sgmii_autoneg.sv - SGMII MAC-side clause 37 style auto-negotiation state machine
module sgmii_autoneg
  import sgmii_pkg::*;
#(
  parameter int          LINK_TIMER    = 200000,
  parameter int          MATCH_COUNT   = 3,
  parameter logic [15:0] LOCAL_ABILITY = 16'h4001
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        rx_sync,
  input  logic        rx_config_valid,
  input  logic [15:0] rx_config_word,
  input  logic        rx_idle_valid,
  input  logic        an_restart_config,
  output logic        tx_config_en,
  output logic [15:0] tx_config_word,
  output logic [15:0] eth_status
);

  localparam int               MC_W   = $clog2(MATCH_COUNT + 1);
  localparam logic [MC_W-1:0]  MC_MAX = MC_W'(MATCH_COUNT);
  localparam logic [15:0] ABILITY_WORD = LOCAL_ABILITY & ~CW_ACK_MASK;
  localparam logic [15:0] ACK_WORD     = LOCAL_ABILITY | CW_ACK_MASK;

  an_state_e        state, state_next;
  logic [15:0]      partner_word, partner_next;
  logic [15:0]      last_word, last_next;
  logic [MC_W-1:0]  match_cnt, match_next;
  logic [MC_W-1:0]  idle_cnt, idle_next;
  logic             restart_req;
  logic             timer_clear;
  logic             timer_expired;
  logic             tx_en_next;
  logic [15:0]      tx_word_next;
  logic [15:0]      status_next;

  sgmii_an_timer #(
    .LINK_TIMER(LINK_TIMER)
  ) u_timer (
    .clock  (clock),
    .reset_n(reset_n),
    .clear  (timer_clear),
    .expired(timer_expired)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= AN_RESTART;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next   = state;
    partner_next = partner_word;
    last_next    = last_word;
    match_next   = match_cnt;
    idle_next    = idle_cnt;
    restart_req  = !rx_sync || an_restart_config ||
                   (rx_config_valid && (rx_config_word == 16'h0000));

    if ((state != AN_RESTART) && restart_req) begin
      state_next = AN_RESTART;
    end else begin
      case (state)
        AN_RESTART: begin
          if (timer_expired && !an_restart_config) state_next = ABILITY_DETECT;
        end
        ABILITY_DETECT: begin
          if (rx_config_valid) begin
            // A differing word counts as the first of a new run, not zero.
            if ((match_cnt != '0) && cw_match_no_ack(rx_config_word, last_word)) begin
              match_next = (match_cnt == MC_MAX) ? MC_MAX : match_cnt + MC_W'(1);
            end else begin
              match_next = MC_W'(1);
            end
            last_next = rx_config_word;
            if (match_next == MC_MAX) begin
              state_next   = ACK_DETECT;
              partner_next = rx_config_word;
            end
          end
        end
        ACK_DETECT: begin
          if (rx_config_valid) begin
            if (!cw_match_no_ack(rx_config_word, partner_word)) begin
              state_next = AN_RESTART;
            end else if (rx_config_word[CW_ACK]) begin
              match_next = (match_cnt == MC_MAX) ? MC_MAX : match_cnt + MC_W'(1);
              if (match_next == MC_MAX) state_next = COMPLETE_ACK;
            end else begin
              match_next = '0;
            end
          end
        end
        COMPLETE_ACK: begin
          if (timer_expired) state_next = IDLE_DETECT;
        end
        IDLE_DETECT: begin
          if (rx_config_valid) begin
            idle_next = '0;
          end else if (rx_idle_valid && (idle_cnt != MC_MAX)) begin
            idle_next = idle_cnt + MC_W'(1);
          end
          if ((idle_next == MC_MAX) && timer_expired) state_next = LINK_OK;
        end
        LINK_OK: begin
          state_next = LINK_OK;
        end
        default: state_next = AN_RESTART;
      endcase
    end

    if (state_next != state) begin
      match_next = '0;
      idle_next  = '0;
    end
  end

  assign timer_clear = (state_next != state);

  // Outputs are decoded from the next state so they register alongside it.
  always_comb begin
    tx_en_next              = 1'b1;
    tx_word_next            = 16'h0000;
    status_next             = 16'h0000;
    status_next[ST_AN_BUSY] = 1'b1;
    case (state_next)
      ABILITY_DETECT: tx_word_next = ABILITY_WORD;
      ACK_DETECT,
      COMPLETE_ACK:   tx_word_next = ACK_WORD;
      IDLE_DETECT:    tx_en_next   = 1'b0;
      LINK_OK: begin
        tx_en_next                            = 1'b0;
        status_next                           = 16'h0000;
        status_next[ST_AN_DONE]               = 1'b1;
        status_next[ST_LINK_UP]               = partner_next[CW_LINK];
        status_next[ST_SPEED_HI:ST_SPEED_LO]  = partner_next[CW_SPEED_HI:CW_SPEED_LO];
        status_next[ST_DUPLEX]                = partner_next[CW_DUPLEX];
      end
      default: tx_word_next = 16'h0000;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      partner_word   <= 16'h0000;
      last_word      <= 16'h0000;
      match_cnt      <= '0;
      idle_cnt       <= '0;
      tx_config_en   <= 1'b1;
      tx_config_word <= 16'h0000;
      eth_status     <= 16'h0020;
    end else begin
      partner_word   <= partner_next;
      last_word      <= last_next;
      match_cnt      <= match_next;
      idle_cnt       <= idle_next;
      tx_config_en   <= tx_en_next;
      tx_config_word <= tx_word_next;
      eth_status     <= status_next;
    end
  end

endmodule

// File: tb/tb_sgmii_autoneg.sv
// tb/tb_sgmii_autoneg.sv - directed self-checking bench for sgmii_autoneg
module tb_sgmii_autoneg;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        rx_sync;
  logic        rx_config_valid;
  logic [15:0] rx_config_word;
  logic        rx_idle_valid;
  logic        an_restart_config;
  logic        tx_config_en;
  logic [15:0] tx_config_word;
  logic [15:0] eth_status;

  int checks = 0;
  int errors = 0;

  sgmii_autoneg #(
    .LINK_TIMER   (100),
    .MATCH_COUNT  (3),
    .LOCAL_ABILITY(16'h4001)
  ) dut (
    .clock            (clock),
    .reset_n          (reset_n),
    .rx_sync          (rx_sync),
    .rx_config_valid  (rx_config_valid),
    .rx_config_word   (rx_config_word),
    .rx_idle_valid    (rx_idle_valid),
    .an_restart_config(an_restart_config),
    .tx_config_en     (tx_config_en),
    .tx_config_word   (tx_config_word),
    .eth_status       (eth_status)
  );

  always #5 clock = ~clock;

  task automatic cycles(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic send_cfg(input logic [15:0] w);
    rx_config_valid = 1'b1;
    rx_config_word  = w;
    @(negedge clock);
    rx_config_valid = 1'b0;
  endtask

  task automatic send_idle();
    rx_idle_valid = 1'b1;
    @(negedge clock);
    rx_idle_valid = 1'b0;
  endtask

  task automatic send_both(input logic [15:0] w);
    rx_config_valid = 1'b1;
    rx_idle_valid   = 1'b1;
    rx_config_word  = w;
    @(negedge clock);
    rx_config_valid = 1'b0;
    rx_idle_valid   = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    rx_sync = 1'b1;
    rx_config_valid = 1'b0;
    rx_config_word = 16'h0000;
    rx_idle_valid = 1'b0;
    an_restart_config = 1'b0;
    cycles(3);
    checks++;
    if (tx_config_en !== 1'b1) begin errors++; $display("FAIL reset_tx_en got=%b exp=1", tx_config_en); end
    checks++;
    if (tx_config_word !== 16'h0000) begin errors++; $display("FAIL reset_tx_word got=%h exp=0000", tx_config_word); end
    checks++;
    if (eth_status !== 16'h0020) begin errors++; $display("FAIL reset_status got=%h exp=0020", eth_status); end
    reset_n = 1'b1;
  endtask

  task automatic test_restart_timer();
    cycles(99);
    checks++;
    if (tx_config_word !== 16'h0000) begin errors++; $display("FAIL restart_early got=%h exp=0000", tx_config_word); end
    cycles(1);
    checks++;
    if (tx_config_word !== 16'h0001) begin errors++; $display("FAIL ability_entry got=%h exp=0001", tx_config_word); end
    checks++;
    if (tx_config_en !== 1'b1) begin errors++; $display("FAIL ability_tx_en got=%b exp=1", tx_config_en); end
  endtask

  task automatic test_ability_mismatch();
    send_cfg(16'hD801);
    send_cfg(16'hD801);
    send_cfg(16'hD805);
    checks++;
    if (tx_config_word !== 16'h0001) begin errors++; $display("FAIL ability_after_diff got=%h exp=0001", tx_config_word); end
    send_cfg(16'h9801);
    send_cfg(16'hD801);
    checks++;
    if (tx_config_word !== 16'h0001) begin errors++; $display("FAIL ability_two_of_three got=%h exp=0001", tx_config_word); end
    send_cfg(16'h9801);
    checks++;
    if (tx_config_word !== 16'h4001) begin errors++; $display("FAIL ack_entry got=%h exp=4001", tx_config_word); end
  endtask

  task automatic test_ack_complete();
    send_cfg(16'hD801);
    send_cfg(16'hD801);
    checks++;
    if (eth_status !== 16'h0020) begin errors++; $display("FAIL ack_status got=%h exp=0020", eth_status); end
    send_cfg(16'hD801);
    cycles(99);
    checks++;
    if (tx_config_en !== 1'b1) begin errors++; $display("FAIL complete_ack_hold got=%b exp=1", tx_config_en); end
    checks++;
    if (tx_config_word !== 16'h4001) begin errors++; $display("FAIL complete_ack_word got=%h exp=4001", tx_config_word); end
    cycles(1);
    checks++;
    if (tx_config_en !== 1'b0) begin errors++; $display("FAIL idle_entry_tx_en got=%b exp=0", tx_config_en); end
  endtask

  task automatic test_idle_collision();
    send_idle();
    send_idle();
    send_idle();
    checks++;
    if (eth_status !== 16'h0020) begin errors++; $display("FAIL idle_before_timer got=%h exp=0020", eth_status); end
    send_both(16'hD801);
    cycles(100);
    checks++;
    if (eth_status !== 16'h0020) begin errors++; $display("FAIL idle_count_cleared got=%h exp=0020", eth_status); end
    send_idle();
    send_idle();
    send_both(16'hD801);
    checks++;
    if (eth_status !== 16'h0020) begin errors++; $display("FAIL idle_both_strobes got=%h exp=0020", eth_status); end
    send_idle();
    send_idle();
    checks++;
    if (eth_status !== 16'h0020) begin errors++; $display("FAIL idle_two_after_clear got=%h exp=0020", eth_status); end
    send_idle();
    checks++;
    if (eth_status !== 16'h001B) begin errors++; $display("FAIL link_ok_status got=%h exp=001b", eth_status); end
    checks++;
    if (tx_config_en !== 1'b0) begin errors++; $display("FAIL link_ok_tx_en got=%b exp=0", tx_config_en); end
  endtask

  task automatic test_sync_drop();
    rx_sync = 1'b0;
    @(negedge clock);
    rx_sync = 1'b1;
    checks++;
    if (tx_config_en !== 1'b1) begin errors++; $display("FAIL sync_drop_tx_en got=%b exp=1", tx_config_en); end
    checks++;
    if (tx_config_word !== 16'h0000) begin errors++; $display("FAIL sync_drop_tx_word got=%h exp=0000", tx_config_word); end
    checks++;
    if (eth_status !== 16'h0020) begin errors++; $display("FAIL sync_drop_status got=%h exp=0020", eth_status); end
  endtask

  task automatic test_ack_mismatch();
    cycles(100);
    checks++;
    if (tx_config_word !== 16'h0001) begin errors++; $display("FAIL resync_ability got=%h exp=0001", tx_config_word); end
    send_cfg(16'hD801);
    send_cfg(16'hD801);
    send_cfg(16'hD801);
    checks++;
    if (tx_config_word !== 16'h4001) begin errors++; $display("FAIL resync_ack got=%h exp=4001", tx_config_word); end
    send_cfg(16'hD802);
    checks++;
    if (tx_config_word !== 16'h0000) begin errors++; $display("FAIL ack_mismatch_restart got=%h exp=0000", tx_config_word); end
    cycles(100);
    checks++;
    if (tx_config_word !== 16'h0001) begin errors++; $display("FAIL zero_test_ability got=%h exp=0001", tx_config_word); end
    send_cfg(16'h0000);
    checks++;
    if (tx_config_word !== 16'h0000) begin errors++; $display("FAIL zero_word_restart got=%h exp=0000", tx_config_word); end
  endtask

  task automatic test_reset_mid();
    cycles(100);
    send_cfg(16'hD801);
    send_cfg(16'hD801);
    send_cfg(16'hD801);
    checks++;
    if (tx_config_word !== 16'h4001) begin errors++; $display("FAIL mid_reset_ack got=%h exp=4001", tx_config_word); end
    reset_n = 1'b0;
    #1;
    checks++;
    if (tx_config_word !== 16'h0000 || tx_config_en !== 1'b1 || eth_status !== 16'h0020) begin
      errors++;
      $display("FAIL mid_reset_async got=%b/%h/%h exp=1/0000/0020", tx_config_en, tx_config_word, eth_status);
    end
    @(negedge clock);
    reset_n = 1'b1;
    cycles(99);
    checks++;
    if (tx_config_word !== 16'h0000) begin errors++; $display("FAIL mid_reset_full_timer got=%h exp=0000", tx_config_word); end
    cycles(1);
    checks++;
    if (tx_config_word !== 16'h0001) begin errors++; $display("FAIL mid_reset_ability got=%h exp=0001", tx_config_word); end
  endtask

  task automatic test_loopback();
    logic done;
    int   used;
    reset_n = 1'b0;
    an_restart_config = 1'b1;
    cycles(2);
    reset_n = 1'b1;
    cycles(120);
    checks++;
    if (tx_config_word !== 16'h0000) begin errors++; $display("FAIL restart_held got=%h exp=0000", tx_config_word); end
    an_restart_config = 1'b0;
    done = 1'b0;
    used = 0;
    for (int i = 0; i < 400 && !done; i++) begin
      if (i % 4 == 0) begin
        if (tx_config_en) begin
          rx_config_valid = 1'b1;
          rx_config_word  = tx_config_word;
        end else begin
          rx_idle_valid = 1'b1;
        end
      end
      @(negedge clock);
      rx_config_valid = 1'b0;
      rx_idle_valid   = 1'b0;
      used = i + 1;
      if (eth_status[0]) done = 1'b1;
    end
    checks++;
    if (done !== 1'b1) begin errors++; $display("FAIL loopback_timeout cycles=%0d exp_done_within=400", used); end
    checks++;
    if (eth_status !== 16'h0001) begin errors++; $display("FAIL loopback_status got=%h exp=0001", eth_status); end
  endtask

  initial begin
    test_reset();
    test_restart_timer();
    test_ability_mismatch();
    test_ack_complete();
    test_idle_collision();
    test_sync_drop();
    test_ack_mismatch();
    test_reset_mid();
    test_loopback();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sgmii_autoneg.md
SGMII_AUTONEG -- requirements
Module: sgmii_autoneg

Interface
REQ-001 Parameter LINK_TIMER, default 200000, link_timer length in clock cycles (1.6 ms at 125 MHz).
REQ-002 Parameter MATCH_COUNT, default 3, consecutive identical received words needed for a match.
REQ-003 Parameter LOCAL_ABILITY, default 16'h4001, SGMII MAC-side config word, ack bit 14 forced 0.
REQ-004 clock  in  1  125 MHz SGMII clock; the only clock.
REQ-005 reset_n  in  1  asynchronous, active-low reset.
REQ-006 rx_sync  in  1  code-group sync from the 8b/10b decoder.
REQ-007 rx_config_valid  in  1  single-cycle strobe, one complete /C/ ordered set received.
REQ-008 rx_config_word  in  16  config word, valid with rx_config_valid.
REQ-009 rx_idle_valid  in  1  single-cycle strobe, one /I/ ordered set received.
REQ-010 an_restart_config  in  1  level; 1 holds negotiation in restart.
REQ-011 tx_config_en  out  1  1 = encoder transmits /C/, 0 = /I/ or data.
REQ-012 tx_config_word  out  16  word for the encoder to send in /C/.
REQ-013 eth_status  out  16  [0] an_done, [1] link_up, [3:2] partner speed, [4] partner duplex, [5] an_busy, [15:6] 0.

Function
REQ-014 States: AN_RESTART, ABILITY_DETECT, ACK_DETECT, COMPLETE_ACK, IDLE_DETECT, LINK_OK.
REQ-015 AN_RESTART: tx_config_en=1, tx_config_word=0; go to ABILITY_DETECT when link_timer expires and an_restart_config=0.
REQ-016 ABILITY_DETECT: send LOCAL_ABILITY with bit14=0; on ability_match with nonzero word, latch partner word, go ACK_DETECT.
REQ-017 ability_match: MATCH_COUNT consecutive rx_config_valid words equal ignoring bit 14; any differing word restarts count at 1.
REQ-018 ACK_DETECT: send LOCAL_ABILITY with bit14=1; on acknowledge_match (MATCH_COUNT consecutive words equal to latched word, bit14=1) go COMPLETE_ACK; a word differing from the latched word outside bit 14 goes AN_RESTART.
REQ-019 COMPLETE_ACK: keep sending acked word; after link_timer expiry go IDLE_DETECT.
REQ-020 IDLE_DETECT: tx_config_en=0; after MATCH_COUNT consecutive rx_idle_valid and link_timer expiry go LINK_OK; any rx_config_valid clears the idle count.
REQ-021 LINK_OK: tx_config_en=0, eth_status[0]=1, eth_status[1]=partner bit 15, [3:2]=partner bits 11:10, [4]=partner bit 12.
REQ-022 In any state except AN_RESTART: rx_sync=0, or an_restart_config=1, or rx_config_valid with word 0 goes AN_RESTART next cycle.
REQ-023 link_timer: counter cleared on every state entry, expiry flag set at count LINK_TIMER-1 and held until next state entry; width $clog2(LINK_TIMER).
REQ-024 Simultaneous rx_config_valid and rx_idle_valid: rx_config_valid takes priority.
REQ-025 All outputs registered; state change visible on outputs one cycle after the qualifying input.
REQ-026 eth_status[5]=1 in every state except LINK_OK.

Reset
REQ-027 reset_n low: state AN_RESTART, counters and latched word 0, tx_config_en=1, tx_config_word=0, eth_status=16'h0020.
REQ-028 reset_n low mid-negotiation aborts immediately; after release, negotiation restarts with full link_timer.

Structure
REQ-029 Package sgmii_pkg holds the state enum, eth_status bit index constants, config-word bit positions (ACK=14, LINK=15, DUPLEX=12, SPEED=11:10).
REQ-030 One sub-module sgmii_an_timer implements link_timer (clear, expired).
REQ-031 Match counters are kept inline, not split into sub-modules.

Verification
REQ-032 Loopback: tx_config_word fed back as rx_config_word, strobe every 4 cycles, LINK_TIMER=100 -> eth_status[0]=1 within 400 cycles of restart release, eth_status=16'h0001 for 16'h4001.
REQ-033 Partner word 16'hD801 with ack -> LINK_OK, eth_status[1]=1, [3:2]=2'b10, [4]=1, eth_status=16'h001B.
REQ-034 Two matching words then a different word -> stays ABILITY_DETECT, tx bit14=0, count restarts.
REQ-035 rx_sync drops in LINK_OK -> next cycle tx_config_en=1, tx_config_word=0, eth_status=16'h0020.
REQ-036 reset_n asserted in ACK_DETECT -> outputs at reset values same cycle, no LINK_OK before full link_timer.
REQ-037 Config and idle strobes same cycle during IDLE_DETECT -> idle count cleared, LINK_OK delayed.
